// File: rtl/arb_pkg.sv
// Shared types and helpers for the round-robin arbiter.
package arb_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } arb_state_e;

    // Index width with a floor of one bit so single-bit cases still have a port.
    function automatic int idx_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Rotating-priority first-one finder: the scan starts at ptr and wraps around.
module rr_pick #(
    parameter int N    = 4,
    parameter int IDXW = 2
) (
    input  logic [N-1:0]    req,
    input  logic [IDXW-1:0] ptr,
    input  logic [IDXW-1:0] mask_idx,
    input  logic            mask_en,
    output logic            found,
    output logic [IDXW-1:0] idx,
    output logic [N-1:0]    onehot
);

    logic [N-1:0] mask_vec;
    logic [N-1:0] masked;
    logic [N-1:0] rot;
    int           first;
    int           sum;

    // Bit k of rot is channel (ptr+k) mod N, so the lowest set bit is the winner.
    always_comb begin
        mask_vec = '0;
        if (mask_en) begin
            mask_vec[mask_idx] = 1'b1;
        end
        masked = req & ~mask_vec;
        rot    = N'({masked, masked} >> ptr);
        found  = 1'b0;
        first  = 0;
        for (int k = 0; k < N; k++) begin
            if (!found && rot[k]) begin
                found = 1'b1;
                first = k;
            end
        end
        sum = int'(ptr) + first;
        if (sum >= N) begin
            sum = sum - N;
        end
        idx    = '0;
        onehot = '0;
        if (found) begin
            idx         = IDXW'(sum);
            onehot[idx] = 1'b1;
        end
    end

endmodule

// File: rtl/rr_arbiter.sv
// Round-robin arbiter with registered one-hot grant and hold-limit preemption.
module rr_arbiter
    import arb_pkg::*;
#(
    parameter int N        = 4,
    parameter int MAX_HOLD = 8,
    localparam int IDXW    = idx_w(N),
    localparam int HW      = idx_w(MAX_HOLD + 1)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N-1:0]    req,
    output logic [N-1:0]    gnt,
    output logic            gnt_valid,
    output logic [IDXW-1:0] gnt_idx,
    output logic            preempt
);

    arb_state_e      state;
    logic [IDXW-1:0] ptr;
    logic [HW-1:0]   hold_cnt;

    logic [IDXW-1:0] next_ptr;
    logic [IDXW-1:0] pick_ptr;
    logic            pick_found;
    logic [IDXW-1:0] pick_idx;
    logic [N-1:0]    pick_onehot;
    logic            owner_req;
    logic            hold_expired;

    // While busy, the candidate search already uses the rotated pointer and
    // excludes the owner, so the same result serves release and preemption.
    always_comb begin
        next_ptr     = (gnt_idx == IDXW'(N - 1)) ? '0 : gnt_idx + IDXW'(1);
        pick_ptr     = (state == BUSY) ? next_ptr : ptr;
        owner_req    = req[gnt_idx];
        hold_expired = (MAX_HOLD != 0) && (hold_cnt == HW'(MAX_HOLD));
    end

    rr_pick #(
        .N    (N),
        .IDXW (IDXW)
    ) u_pick (
        .req      (req),
        .ptr      (pick_ptr),
        .mask_idx (gnt_idx),
        .mask_en  (state == BUSY),
        .found    (pick_found),
        .idx      (pick_idx),
        .onehot   (pick_onehot)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            ptr       <= '0;
            hold_cnt  <= '0;
            gnt       <= '0;
            gnt_valid <= 1'b0;
            gnt_idx   <= '0;
            preempt   <= 1'b0;
        end else begin
            preempt <= 1'b0;
            case (state)
                IDLE: begin
                    if (pick_found) begin
                        state     <= BUSY;
                        gnt       <= pick_onehot;
                        gnt_valid <= 1'b1;
                        gnt_idx   <= pick_idx;
                        hold_cnt  <= HW'(1);
                    end
                end
                BUSY: begin
                    if (!owner_req) begin
                        ptr <= next_ptr;
                        if (pick_found) begin
                            gnt      <= pick_onehot;
                            gnt_idx  <= pick_idx;
                            hold_cnt <= HW'(1);
                        end else begin
                            state     <= IDLE;
                            gnt       <= '0;
                            gnt_valid <= 1'b0;
                            gnt_idx   <= '0;
                            hold_cnt  <= '0;
                        end
                    end else if (hold_expired && pick_found) begin
                        ptr      <= next_ptr;
                        gnt      <= pick_onehot;
                        gnt_idx  <= pick_idx;
                        hold_cnt <= HW'(1);
                        preempt  <= 1'b1;
                    end else if (hold_cnt < HW'(MAX_HOLD)) begin
                        hold_cnt <= hold_cnt + HW'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rr_arbiter.sv
// Scoreboard bench for rr_arbiter (N=4, MAX_HOLD=4) plus a MAX_HOLD=0 instance.
module tb_rr_arbiter;

    typedef struct {
        logic [3:0] g;
        logic [1:0] i;
        logic       p;
    } exp_t;

    logic       clk;
    logic       rst;
    logic [3:0] req;
    logic [3:0] gnt;
    logic       gnt_valid;
    logic [1:0] gnt_idx;
    logic       preempt;

    logic [3:0] req_nh;
    logic [3:0] gnt_nh;
    logic       gnt_valid_nh;
    logic [1:0] gnt_idx_nh;
    logic       preempt_nh;

    exp_t sb[$];
    int   total;
    int   bad;

    rr_arbiter #(.N(4), .MAX_HOLD(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .gnt       (gnt),
        .gnt_valid (gnt_valid),
        .gnt_idx   (gnt_idx),
        .preempt   (preempt)
    );

    rr_arbiter #(.N(4), .MAX_HOLD(0)) dut_nh (
        .clk       (clk),
        .rst       (rst),
        .req       (req_nh),
        .gnt       (gnt_nh),
        .gnt_valid (gnt_valid_nh),
        .gnt_idx   (gnt_idx_nh),
        .preempt   (preempt_nh)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Drive one cycle of req and queue the grant expected one edge later.
    task automatic applyStimulus(input logic [3:0] r, input logic [3:0] eg, input logic ep);
        exp_t e;
        @(negedge clk);
        req = r;
        e.g = eg;
        e.p = ep;
        e.i = 2'd0;
        for (int k = 0; k < 4; k++) begin
            if (eg[k]) e.i = 2'(k);
        end
        sb.push_back(e);
    endtask

    // Monitor: each cycle, compare the registered outputs against the queue head.
    always begin
        exp_t e;
        @(posedge clk);
        #2;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            checkOutput("gnt", 32'(gnt), 32'(e.g));
            checkOutput("gnt_valid", 32'(gnt_valid), 32'(|e.g));
            checkOutput("gnt_idx", 32'(gnt_idx), 32'(e.i));
            checkOutput("preempt", 32'(preempt), 32'(e.p));
        end else if (!rst) begin
            checkOutput("unexpected_gnt", 32'(gnt_valid), 32'd0);
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: time limit reached, required $finish earlier");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        total  = 0;
        bad    = 0;
        rst    = 1'b1;
        req    = 4'b0000;
        req_nh = 4'b0000;
        repeat (2) @(negedge clk);
        checkOutput("reset_gnt", 32'(gnt), 32'd0);
        checkOutput("reset_valid", 32'(gnt_valid), 32'd0);
        checkOutput("reset_idx", 32'(gnt_idx), 32'd0);
        checkOutput("reset_preempt", 32'(preempt), 32'd0);
        rst = 1'b0;

        $display("[TB] all four requesting, hold limit rotation");
        for (int c = 0; c < 20; c++) begin
            applyStimulus(4'b1111, 4'(1 << ((c / 4) % 4)), (c % 4 == 0) && (c > 0));
        end
        applyStimulus(4'b0000, 4'b0000, 1'b0);

        $display("[TB] lone requester never preempted");
        for (int c = 0; c < 20; c++) begin
            applyStimulus(4'b0100, 4'b0100, 1'b0);
        end
        applyStimulus(4'b0000, 4'b0000, 1'b0);

        $display("[TB] back-to-back handover on release");
        applyStimulus(4'b0010, 4'b0010, 1'b0);
        applyStimulus(4'b1011, 4'b0010, 1'b0);
        applyStimulus(4'b1001, 4'b1000, 1'b0);
        applyStimulus(4'b0000, 4'b0000, 1'b0);

        $display("[TB] pointer wrap");
        applyStimulus(4'b1000, 4'b1000, 1'b0);
        applyStimulus(4'b0011, 4'b0001, 1'b0);
        applyStimulus(4'b1010, 4'b0010, 1'b0);
        applyStimulus(4'b1010, 4'b0010, 1'b0);

        $display("[TB] asynchronous reset mid-grant");
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        checkOutput("async_rst_gnt", 32'(gnt), 32'd0);
        checkOutput("async_rst_valid", 32'(gnt_valid), 32'd0);
        checkOutput("async_rst_idx", 32'(gnt_idx), 32'd0);
        checkOutput("async_rst_preempt", 32'(preempt), 32'd0);
        @(negedge clk);
        req = 4'b0000;
        rst = 1'b0;
        applyStimulus(4'b0110, 4'b0010, 1'b0);
        applyStimulus(4'b0000, 4'b0000, 1'b0);

        $display("[TB] reset restores pointer to channel 0");
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        applyStimulus(4'b1001, 4'b0001, 1'b0);
        applyStimulus(4'b0000, 4'b0000, 1'b0);

        $display("[TB] MAX_HOLD=0 instance holds indefinitely");
        @(negedge clk);
        req_nh = 4'b0011;
        for (int c = 0; c < 50; c++) begin
            @(posedge clk);
            #3;
            checkOutput("nh_gnt", 32'(gnt_nh), 32'd1);
            checkOutput("nh_preempt", 32'(preempt_nh), 32'd0);
        end
        req_nh = 4'b0000;

        repeat (3) @(negedge clk);
        checkOutput("sb_drained", 32'(sb.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/rr_arbiter.md
# rr_arbiter

Parametrised round-robin arbiter that grants one of `N` requesters at a time with a one-hot, registered grant. A grant is held until its owner drops its request or a hold limit expires. It replaces the fixed four-channel arbiter at shared-resource front ends such as bus masters and memory ports. Fairness comes from a rotating priority pointer; there is no external pointer-advance event.

## Interface
Parameters:
- `N`, 4: number of requesters; legal range 2..32.
- `MAX_HOLD`, 8: maximum consecutive cycles a grant may be held while others are waiting; 0 disables preemption.

Ports:
- `clk`, input, 1: single clock; all state updates on the rising edge.
- `rst`, input, 1: reset, asynchronous and active-high.
- `req`, input, N: request per channel, level-sensitive.
- `gnt`, output, N: one-hot grant, registered; all zeros when idle.
- `gnt_valid`, output, 1: OR of `gnt`, registered.
- `gnt_idx`, output, IDXW: index of the granted channel; 0 when idle. IDXW = max(1, clog2(N)).
- `preempt`, output, 1: one-cycle pulse, registered; the grant changed because the hold limit expired.

## Operation
- State machine has two states:
  - IDLE: `gnt`=0.
  - BUSY: exactly one `gnt` bit is set.
- Winner selection: scan `req` circularly starting at `ptr`. The first set bit wins.
- `ptr` is the highest-priority index. Reset value is 0.
- Each time a grant ends, `ptr` becomes owner+1 mod N.
- IDLE:
  - If `req` != 0, go to BUSY with the winner granted; `hold_cnt` = 1.
  - Otherwise stay in IDLE.
- BUSY, evaluated on the sampled `req`:
  - Release: the owner's `req` is low. Rotate `ptr`, then pick a winner among the remaining requests.
    - If there is one, grant it directly (back-to-back, no idle cycle) and set `hold_cnt` = 1.
    - If there is none, go to IDLE.
  - Preempt: the owner's `req` is high, `MAX_HOLD` != 0, `hold_cnt` == `MAX_HOLD`, and any other `req` is high. Rotate `ptr`, grant the next winner, set `hold_cnt` = 1, and pulse `preempt`.
  - Otherwise keep the grant. `hold_cnt` increments and saturates at `MAX_HOLD`.
- If the owner is alone, it keeps the grant indefinitely and is never preempted. `hold_cnt` saturates.
- A preempted owner that still requests re-enters arbitration at its rotated priority, i.e. lowest.
- `hold_cnt` width is clog2(MAX_HOLD+1), with a minimum of 1.
- Reset values: `gnt`=0, `gnt_valid`=0, `gnt_idx`=0, `preempt`=0, `ptr`=0, `hold_cnt`=0, state IDLE.
- Reset asserted mid-grant clears everything asynchronously. Arbitration after reset restarts with channel 0 at top priority.

## Timing
- Latency from `req` rising to `gnt` is 1 cycle, as registered outputs.
- Handover from owner `req` falling to the new `gnt` is 1 cycle. The old grant and the new grant never overlap.
- `preempt` is asserted in the same cycle the new `gnt` first appears.
- A requester must hold `req` until it sees `gnt`. A `req` pulse that drops before being granted is lost; this is legal, with no latching.
- Simultaneous requests on any subset are resolved purely by `ptr` order.
- Pointer wrap: owner N-1 rotates `ptr` to 0.

## Structure
- Shared package `arb_pkg`:
  - `arb_state_e` enum (IDLE, BUSY).
  - Function `idx_w(n)` returning max(1, clog2(n)).
- Sub-module `rr_pick`:
  - Combinational rotate-priority encoder.
  - Inputs: `req` [N], `ptr` [IDXW], `mask_idx` and `mask_en` (the mask excludes the current owner).
  - Outputs: `found`, `idx`, `onehot`.
  - Implemented as a double-width request vector shifted by `ptr`, then a first-one search.
- Top level holds the state register, `ptr`, `hold_cnt`, and the output registers.

## Test plan
Bench configuration is N=4, MAX_HOLD=4.
1. Reset then `req`=4'b1111 held: grants go 0 (4 cycles, then `preempt`), 1, 2, 3, 0. Every handover pulses `preempt`.
2. `req`=4'b0100 alone, held for 20 cycles: `gnt`=4'b0100 from cycle 1, `preempt` never asserts, `gnt_idx`=2.
3. Owner 1 drops `req` while `req`=4'b1011: the next cycle `gnt`=4'b1000, with no idle cycle. Then `req`=0 gives `gnt`=0 one cycle later.
4. Wrap: channel 3 granted and released with `req`=4'b0011 pending, so 0 wins over 1. Then `ptr`=1 after 0 releases.
5. Assert `rst` mid-grant, asynchronously between edges: all outputs read 0 immediately. After release, `req`=4'b0110 gives a grant to 1.
6. MAX_HOLD=0 build, `req`=4'b0011 held for 50 cycles: channel 0 is granted the whole time and `preempt` stays 0.
